// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg
// Shared definitions for the RV32IM instruction encoder: opcode and funct7
// constants (the same values the decoder's define.vh uses), the funct3 values
// that matter to the encoder, the FSM state encoding and small funct3
// legality helpers.
package instr_encoder_pkg;

    // Major opcodes, instr[6:0]
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // funct7 values
    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_MULDIV = 7'h01;
    localparam logic [6:0] F7_ALT    = 7'h20;

    // funct3 values with special meaning to the encoder
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_JALR    = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_WRITE,
        ST_DONE
    } enc_state_t;

    // BEQ/BNE/BLT/BGE/BLTU/BGEU; 010 and 011 are unassigned
    function automatic logic branch_f3_ok(input logic [2:0] f3);
        return (f3 != 3'b010) && (f3 != 3'b011);
    endfunction

    // LB/LH/LW/LBU/LHU
    function automatic logic load_f3_ok(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
               (f3 == 3'b100) || (f3 == 3'b101);
    endfunction

    // SB/SH/SW
    function automatic logic store_f3_ok(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// instr_pack
// Purely combinational field packer. Takes one instruction record and
// produces the 32-bit RV32IM word plus a legality flag.
// Ports:
//   opcode, funct3, funct7, rd, rs1, rs2 : instruction fields
//   imm                                  : sign-extended immediate as the decoder emits it
//   word                                 : packed instruction (0 for unknown opcodes)
//   legal                                : record is encodable without loss
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        legal
);

    // An immediate fits N-bit signed when every bit from N-1 upward equals the sign.
    logic i_fit;
    logic b_fit;
    logic j_fit;
    logic is_shift;

    assign i_fit    = (&imm[31:11]) | ~(|imm[31:11]);
    assign b_fit    = (&imm[31:12]) | ~(|imm[31:12]);
    assign j_fit    = (&imm[31:20]) | ~(|imm[31:20]);
    assign is_shift = (funct3 == F3_SLL) || (funct3 == F3_SRL_SRA);

    always_comb begin
        word  = 32'h0;
        legal = 1'b0;
        case (opcode)
            OPC_OP: begin
                word  = {funct7, rs2, rs1, funct3, rd, opcode};
                // funct7 0x20 only exists for SUB and SRA
                legal = (funct7 == F7_BASE) || (funct7 == F7_MULDIV) ||
                        ((funct7 == F7_ALT) &&
                         ((funct3 == F3_ADD_SUB) || (funct3 == F3_SRL_SRA)));
            end
            OPC_OPIMM: begin
                if (is_shift) begin
                    word  = {funct7, imm[4:0], rs1, funct3, rd, opcode};
                    legal = (imm[31:5] == 27'h0) &&
                            ((funct7 == F7_BASE) ||
                             ((funct7 == F7_ALT) && (funct3 == F3_SRL_SRA)));
                end else begin
                    word  = {imm[11:0], rs1, funct3, rd, opcode};
                    legal = i_fit;
                end
            end
            OPC_LOAD: begin
                word  = {imm[11:0], rs1, funct3, rd, opcode};
                legal = i_fit && load_f3_ok(funct3);
            end
            OPC_JALR: begin
                word  = {imm[11:0], rs1, funct3, rd, opcode};
                legal = i_fit && (funct3 == F3_JALR);
            end
            OPC_STORE: begin
                word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                legal = i_fit && store_f3_ok(funct3);
            end
            OPC_BRANCH: begin
                word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                legal = b_fit && !imm[0] && branch_f3_ok(funct3);
            end
            OPC_LUI, OPC_AUIPC: begin
                word  = {imm[31:12], rd, opcode};
                legal = (imm[11:0] == 12'h0);
            end
            OPC_JAL: begin
                word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                legal = j_fit && !imm[0];
            end
            default: begin
                word  = 32'h0;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder
// Accepts instruction field records over a valid/ready stream, packs each
// into an RV32IM word and writes the words to consecutive imem addresses.
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   start                     : begins a new program (priority over everything)
//   in_valid / in_ready       : record handshake; in_ready depends on state only
//   in_opcode .. in_imm       : record fields
//   in_last                   : final record of the program
//   imem_we/addr/wdata        : one-cycle word write strobe with address and data
//   count                     : words written since start
//   busy, done, err           : status; err is sticky until the next start
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int          IMEM_ADDR_W = 14,
    parameter int unsigned BASE_ADDR   = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [6:0]             in_opcode,
    input  logic [2:0]             in_funct3,
    input  logic [6:0]             in_funct7,
    input  logic [4:0]             in_rd,
    input  logic [4:0]             in_rs1,
    input  logic [4:0]             in_rs2,
    input  logic [31:0]            in_imm,
    input  logic                   in_last,
    output logic                   imem_we,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    output logic [31:0]            imem_wdata,
    output logic [IMEM_ADDR_W:0]   count,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam logic [IMEM_ADDR_W-1:0] BASE = BASE_ADDR[IMEM_ADDR_W-1:0];

    enc_state_t             state;
    enc_state_t             next_state;
    logic [IMEM_ADDR_W-1:0] addr_q;
    logic [IMEM_ADDR_W:0]   count_q;
    logic [31:0]            word_q;
    logic                   last_q;
    logic                   err_q;
    logic [31:0]            pack_word;
    logic                   pack_legal;
    logic                   mem_full;
    logic                   accept_ok;
    logic                   handshake;

    instr_pack u_pack (
        .opcode (in_opcode),
        .funct3 (in_funct3),
        .funct7 (in_funct7),
        .rd     (in_rd),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .imm    (in_imm),
        .word   (pack_word),
        .legal  (pack_legal)
    );

    // Memory is full once count reaches 2^IMEM_ADDR_W, i.e. only the top bit is set.
    assign mem_full  = count_q[IMEM_ADDR_W];
    assign accept_ok = pack_legal && !mem_full;
    assign handshake = (state == ST_ACCEPT) && in_valid && !start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and outputs. imem_we is masked by start so a write pending
    // in the same cycle as a restart never reaches memory.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        imem_we    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_ACCEPT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    if (accept_ok) begin
                        next_state = ST_WRITE;
                    end else if (in_last) begin
                        next_state = ST_DONE;
                    end
                end
            end
            ST_WRITE: begin
                busy       = 1'b1;
                imem_we    = !start;
                next_state = last_q ? ST_DONE : ST_ACCEPT;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                next_state = state;
            end
        endcase
        if (start) begin
            next_state = ST_ACCEPT;
        end
    end

    // Datapath registers: restart clears address/count/err; a handshake
    // captures the word (legal only) and last flag; the write cycle advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= BASE;
            count_q <= '0;
            word_q  <= 32'h0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (start) begin
            addr_q  <= BASE;
            count_q <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (handshake) begin
            last_q <= in_last;
            if (accept_ok) begin
                word_q <= pack_word;
            end else begin
                err_q <= 1'b1;
            end
        end else if (state == ST_WRITE) begin
            addr_q  <= addr_q + IMEM_ADDR_W'(1);
            count_q <= count_q + (IMEM_ADDR_W + 1)'(1);
        end
    end

    assign imem_addr  = addr_q;
    assign imem_wdata = word_q;
    assign count      = count_q;
    assign err        = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder
// Directed self-checking bench for instr_encoder. Built with a 3-bit word
// address so the full-memory rejection is reachable in a few cycles.
module tb_instr_encoder;

    localparam int AW = 3;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [6:0]    in_opcode;
    logic [2:0]    in_funct3;
    logic [6:0]    in_funct7;
    logic [4:0]    in_rd;
    logic [4:0]    in_rs1;
    logic [4:0]    in_rs2;
    logic [31:0]   in_imm;
    logic          in_last;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   count;
    logic          busy;
    logic          done;
    logic          err;

    int vectors    = 0;
    int miscompares = 0;
    int back_to_back = 0;
    logic prev_we = 1'b0;

    instr_encoder #(.IMEM_ADDR_W(AW), .BASE_ADDR(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_funct3  (in_funct3),
        .in_funct7  (in_funct7),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .in_last    (in_last),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two write strobes on consecutive cycles would break the 1-per-2 throughput.
    always @(negedge clk) begin
        if (imem_we && prev_we) back_to_back++;
        prev_we = imem_we;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Offers one record at a negedge, waits (bounded) for in_ready, lets the
    // handshake edge pass and returns at the following negedge.
    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [31:0] imm, input logic last);
        int waited;
        in_opcode = op;
        in_funct3 = f3;
        in_funct7 = f7;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm    = imm;
        in_last   = last;
        in_valid  = 1'b1;
        waited    = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("handshake_ready", 32'(in_ready), 32'd1);
        if (in_ready) begin
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic checkWrite(input string tag, input logic [AW-1:0] addr,
                              input logic [31:0] data);
        checkOutput({tag, "_we"}, 32'(imem_we), 32'd1);
        checkOutput({tag, "_addr"}, 32'(imem_addr), 32'(addr));
        checkOutput({tag, "_data"}, imem_wdata, data);
    endtask

    // Independent decoder used for the round-trip check.
    function automatic logic [31:0] decodeImm(input logic [31:0] w);
        case (w[6:0])
            7'h13, 7'h03, 7'h67: return {{20{w[31]}}, w[31:20]};
            7'h23: return {{20{w[31]}}, w[31:25], w[11:7]};
            7'h63: return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            7'h6F: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            7'h37, 7'h17: return {w[31:12], 12'h0};
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        logic [31:0] r;
        logic [31:0] imm;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  opimm_f3 [6];
        opimm_f3 = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b110, 3'b111};

        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_opcode = '0; in_funct3 = '0; in_funct7 = '0;
        in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        repeat (2) @(negedge clk);

        checkOutput("rst_we", 32'(imem_we), 0);
        checkOutput("rst_addr", 32'(imem_addr), 0);
        checkOutput("rst_wdata", imem_wdata, 0);
        checkOutput("rst_count", 32'(count), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_err", 32'(err), 0);
        checkOutput("rst_ready", 32'(in_ready), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // addi x1,x0,5 as a one-instruction program
        pulseStart();
        checkOutput("accept_busy", 32'(busy), 1);
        applyStimulus(7'h13, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
        checkWrite("addi", 0, 32'h00500093);
        @(negedge clk);
        checkOutput("addi_done", 32'(done), 1);
        checkOutput("addi_count", 32'(count), 1);
        checkOutput("addi_busy", 32'(busy), 0);

        // add x3,x1,x2 ; sw x2,8(x1)
        pulseStart();
        applyStimulus(7'h33, 3'b000, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        checkWrite("add", 0, 32'h002081B3);
        applyStimulus(7'h23, 3'b010, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1);
        checkWrite("sw", 1, 32'h0020A423);
        @(negedge clk);
        checkOutput("sw_count", 32'(count), 2);

        // Branch, jump, upper-immediate and arithmetic shift formats
        pulseStart();
        applyStimulus(7'h63, 3'b000, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b0);
        checkWrite("beq", 0, 32'hFE208EE3);
        applyStimulus(7'h6F, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd8, 1'b0);
        checkWrite("jal", 1, 32'h008000EF);
        applyStimulus(7'h37, 3'b000, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b0);
        checkWrite("lui", 2, 32'h123452B7);
        applyStimulus(7'h13, 3'b101, 7'h20, 5'd4, 5'd1, 5'd0, 32'd3, 1'b1);
        checkWrite("srai", 3, 32'h4030D213);

        // I-immediate just out of range is dropped, next record goes to addr 0
        pulseStart();
        applyStimulus(7'h13, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0);
        checkOutput("imm2048_we", 32'(imem_we), 0);
        checkOutput("imm2048_err", 32'(err), 1);
        applyStimulus(7'h13, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
        checkWrite("after_imm2048", 0, 32'h00500093);

        // Odd branch offset is dropped; err was cleared by the restart first
        pulseStart();
        checkOutput("err_cleared", 32'(err), 0);
        applyStimulus(7'h63, 3'b000, 7'h00, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0);
        checkOutput("bimm3_we", 32'(imem_we), 0);
        checkOutput("bimm3_err", 32'(err), 1);
        applyStimulus(7'h13, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
        checkWrite("after_bimm3", 0, 32'h00500093);

        // Unknown opcode flagged last ends the program without a write
        pulseStart();
        applyStimulus(7'h7F, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd0, 1'b1);
        checkOutput("badop_we", 32'(imem_we), 0);
        checkOutput("badop_done", 32'(done), 1);
        checkOutput("badop_err", 32'(err), 1);
        checkOutput("badop_count", 32'(count), 0);

        // Round trip through the bench decoder, one record per format
        pulseStart();
        for (int i = 0; i < 6; i++) begin
            r   = $urandom;
            rd  = 5'($urandom_range(1, 31));
            rs1 = 5'($urandom_range(0, 31));
            rs2 = 5'($urandom_range(0, 31));
            f3  = 3'b000;
            f7  = 7'h00;
            case (i)
                0: begin op = 7'h33; f3 = 3'($urandom_range(0, 7));
                         f7 = (r[0]) ? 7'h01 : 7'h00; imm = 32'h0; end
                1: begin op = 7'h13; f3 = opimm_f3[$urandom_range(0, 5)];
                         imm = {{20{r[11]}}, r[11:0]}; end
                2: begin op = 7'h23; f3 = 3'($urandom_range(0, 2));
                         imm = {{20{r[11]}}, r[11:0]}; end
                3: begin op = 7'h63; imm = {{19{r[12]}}, r[12:1], 1'b0}; end
                4: begin op = 7'h6F; imm = {{11{r[20]}}, r[20:1], 1'b0}; end
                default: begin op = 7'h37; imm = {r[31:12], 12'h0}; end
            endcase
            applyStimulus(op, f3, f7, rd, rs1, rs2, imm, 1'b0);
            checkOutput("rt_we", 32'(imem_we), 1);
            checkOutput("rt_opcode", 32'(imem_wdata[6:0]), 32'(op));
            if (i != 2 && i != 3) checkOutput("rt_rd", 32'(imem_wdata[11:7]), 32'(rd));
            if (i <= 3) checkOutput("rt_rs1", 32'(imem_wdata[19:15]), 32'(rs1));
            if (i == 0 || i == 2 || i == 3)
                checkOutput("rt_rs2", 32'(imem_wdata[24:20]), 32'(rs2));
            if (i != 0) checkOutput("rt_imm", decodeImm(imem_wdata), imm);
        end

        // Fill all 8 words, the ninth record is rejected as memory full
        pulseStart();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(7'h13, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'(i), 1'b0);
            checkWrite("fill", AW'(i), {12'(i), 20'h00093});
        end
        applyStimulus(7'h13, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd9, 1'b0);
        checkOutput("full_we", 32'(imem_we), 0);
        checkOutput("full_err", 32'(err), 1);
        checkOutput("full_count", 32'(count), 8);

        // start during the write cycle suppresses the strobe and restarts
        pulseStart();
        applyStimulus(7'h33, 3'b000, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        start = 1'b1;
        #1;
        checkOutput("start_in_write_we", 32'(imem_we), 0);
        @(negedge clk);
        start = 1'b0;
        checkOutput("restart_count", 32'(count), 0);
        checkOutput("restart_ready", 32'(in_ready), 1);
        applyStimulus(7'h13, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
        checkWrite("after_restart", 0, 32'h00500093);

        // Reset in the middle of a write returns everything to zero
        applyStimulus(7'h33, 3'b000, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_we", 32'(imem_we), 0);
        checkOutput("midrst_addr", 32'(imem_addr), 0);
        checkOutput("midrst_wdata", imem_wdata, 0);
        checkOutput("midrst_count", 32'(count), 0);
        checkOutput("midrst_busy", 32'(busy), 0);
        checkOutput("midrst_ready", 32'(in_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        checkOutput("throughput", 32'(back_to_back), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

RV32IM instruction encoder and instruction-memory writer: the encode-side counterpart of the core's instruction decoder. It accepts field records (opcode, funct3, funct7, rd, rs1, rs2, sign-extended imm) over a valid/ready stream and packs each into a 32-bit instruction word. It checks field legality and writes the words sequentially into instruction memory. It sits between the boot/self-test program source and the imem write port, and is used to build test programs without an external assembler.

## Interface
Parameters:
- `IMEM_ADDR_W`, 14, imem word-address width
- `BASE_ADDR`, 0, first word address written after `start`

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  pulse; begins a new program
- `in_valid`  in  1  record valid
- `in_ready`  out  1  encoder can accept a record
- `in_opcode`  in  7  opcode[6:0]
- `in_funct3`  in  3  funct3
- `in_funct7`  in  7  funct7 (R-type and shift-immediate)
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register numbers
- `in_imm`  in  32  immediate, in the same form the decoder outputs it
- `in_last`  in  1  final record of the program
- `imem_we`  out  1  word write strobe
- `imem_addr`  out  IMEM_ADDR_W  word address
- `imem_wdata`  out  32  encoded instruction
- `count`  out  IMEM_ADDR_W+1  words written since `start`
- `busy`  out  1  state is ACCEPT or WRITE
- `done`  out  1  program complete
- `err`  out  1  sticky; a record was rejected

## Operation
- States: IDLE, ACCEPT, WRITE, DONE.
- IDLE/DONE + `start`: go to ACCEPT. Set addr counter = BASE_ADDR, `count`=0, clear `err`.
- ACCEPT: `in_ready`=1. A handshake (`in_valid`&`in_ready`) registers the encoded word and `in_last`.
  - Legal record: go to WRITE.
  - Illegal record: set `err`, drop the record (no write). Go to DONE if `in_last`, else stay in ACCEPT.
- WRITE: `imem_we`=1 for exactly one cycle with the registered addr/word. Then addr+1 and `count`+1. Go to DONE if the last flag is set, else go to ACCEPT.
- DONE: `done`=1, held until `start`.
- Encodings, by opcode:
  - OP: {f7,rs2,rs1,f3,rd,op}
  - OPIMM, except funct3 001/101: {imm[11:0],rs1,f3,rd,op}
  - OPIMM shifts (funct3 001/101): {f7,imm[4:0],rs1,f3,rd,op}
  - LOAD and JALR: I-type, {imm[11:0],rs1,f3,rd,op}
  - STORE: {imm[11:5],rs2,rs1,f3,imm[4:0],op}
  - BRANCH: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}
  - LUI/AUIPC: {imm[31:12],rd,op}
  - JAL: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}
- Legality rules; any violation makes the record illegal:
  - opcode must be one of the nine above.
  - I/S imm must fit 12-bit signed (imm[31:11] uniform).
  - B imm must fit 13-bit signed, with imm[0]=0.
  - J imm must fit 21-bit signed, with imm[0]=0.
  - U imm requires imm[11:0]=0.
  - Shifts require imm[31:5]=0 and f7 in {0x00, 0x20 (funct3 101 only)}.
  - OP requires f7 in {0x00, 0x01, 0x20 (funct3 000/101 only)}.
  - funct3 must be a defined value for BRANCH/LOAD/STORE; JALR requires f3=000.
- Full memory: a record accepted when `count` = 2^IMEM_ADDR_W is treated as illegal.

## Timing
- Reset values: all outputs 0; state IDLE; counter = BASE_ADDR.
- Latency: handshake in cycle N gives `imem_we` in cycle N+1. Throughput is 1 word per 2 cycles.
- `in_ready` is a function of state only; it does not depend on `in_valid`.
- `count` and `imem_addr` update on the clock edge that ends the write cycle.
- `start` has priority in every state, including mid-ACCEPT and WRITE:
  - A pending write is discarded, with no `imem_we` in the following cycle.
  - The restart then proceeds as from IDLE.
- `start` coincident with a handshake: the record is ignored.
- `rst_n` low mid-operation: immediate return to reset values; no partial write.

## Structure
- Shared package (alongside the decoder's `define.vh`): opcode constants (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP), the funct7 constants, and the state encoding.
- Sub-module `instr_pack`: combinational field packing and legality check, with outputs `word` and `legal`. The top level holds the FSM, counters and registers.

## Test plan
- addi x1,x0,5 (op 0x13, f3 0, rd 1, imm 5), last → one write: addr 0, data 0x00500093; `done`=1, `count`=1.
- add x3,x1,x2 then sw x2,8(x1) → data 0x002081B3 at addr 0, then 0x0020A423 at addr 1; no more than one `imem_we` per two cycles.
- beq x1,x2,imm=-4 → 0xFE208EE3. jal x1,imm=8 → 0x008000EF. lui x5,imm=0x12345000 → 0x123452B7. srai x4,x1,3 (f7 0x20) → 0x4030D213.
- addi with imm=2048, then a legal addi → `err`=1, no write for the first; the second writes to addr 0. Repeat with branch imm=3: same result.
- Round trip: random legal records → encoder → decoder. The decoder's rd/rs1/rs2/imm/opcode must match the input record.
- `start` asserted in the WRITE cycle → no `imem_we`; `count`=0; the next record is written at BASE_ADDR. Repeat with `rst_n` low mid-stream: all outputs 0.
